max_pool_stream: RTL and testbench



---
 rtl/dataformat_pkg.sv | 24 ++
 rtl/max_pool_stream_partial_buf.sv | 30 +++
 rtl/max_pool_stream.sv | 114 +++++++++++
 tb/tb_max_pool_stream.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataformat_pkg.sv
// Shared data format for the pooling path: value type, max and sizing helpers.
// POOL_SIGNED_EN selects two's-complement comparison in pool_max.
package dataformat;

    localparam int POOL_DW = 8;

    typedef logic [POOL_DW-1:0] pool_data_t;

    function automatic pool_data_t pool_max(
        input pool_data_t a,
        input pool_data_t b
    );
`ifdef POOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    function automatic int ceil_half(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/max_pool_stream_partial_buf.sv
// Partial-max register file, one entry per pooled column of the current row pair.
// Combinational read, single write port, cleared by reset.
module pool_partial_buf #(
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 max pool over a row-major, channel-major frame.
// Define POOL_SIGNED_EN for signed comparison (unsigned otherwise).
module max_pool_stream
    import dataformat::*;
#(
    parameter int DATA_W = 8,
    parameter int MAP_W  = 5,
    parameter int MAP_H  = 5,
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              frame_done
);

    localparam int PW  = ceil_half(MAP_W);
    localparam int PH  = ceil_half(MAP_H);
    localparam int CW  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int RW  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int HW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PIW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CH * PW * PH - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [HW-1:0]     ch;
    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              ch_last;
    logic              win_start;
    logic              win_close;
    logic [PIW-1:0]    idx;
    logic [DATA_W-1:0] pmax;
    logic [DATA_W-1:0] new_max;
    logic [ADDR_W-1:0] addr_nxt;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_last  = (col == CW'(MAP_W - 1));
    assign row_last  = (row == RW'(MAP_H - 1));
    assign ch_last   = (ch == HW'(NUM_CH - 1));
    assign win_start = !row[0] && !col[0];
    assign win_close = (col[0] || col_last) && (row[0] || row_last);
    assign idx       = PIW'(col >> 1);

    // A window start also covers the 1x1 edge window: the beat is the max.
    assign new_max = win_start ? in_data : pool_max(pmax, in_data);

    assign addr_nxt = ADDR_W'(ch) * ADDR_W'(PW * PH)
                    + ADDR_W'(row >> 1) * ADDR_W'(PW)
                    + ADDR_W'(col >> 1);

    pool_partial_buf #(
        .DEPTH  (PW),
        .IDX_W  (PIW),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .idx   (idx),
        .wdata (new_max),
        .rdata (pmax)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    ch  <= ch_last ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output register refills on the same edge it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && (out_addr == LAST);
            if (accept && win_close) begin
                out_valid <= 1'b1;
                out_data  <= new_max;
                out_addr  <= addr_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed and table-driven bench for max_pool_stream on three map geometries.
// Expected values are hand-computed or come from a 2-D reference pool.
module tb_max_pool_stream;

    typedef struct {
        logic [7:0] a;
        logic [7:0] v;
    } res_t;

    typedef struct {
        logic [7:0] px [4];
        logic [7:0] eu;
        logic [7:0] es;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       iv   [3];
    logic       ir   [3];
    logic [7:0] idat [3];
    logic       ov   [3];
    logic       orr  [3];
    logic [7:0] odat [3];
    logic [7:0] oadr [3];
    logic       fd   [3];

    res_t       q [$];
    int         fdc [3];
    logic [7:0] ea [$];
    logic [7:0] ev [$];
    logic [7:0] stim [100];
    vec_t       tbl [6];
    int         nchk;
    int         nerr;
    bit         sdone;

    max_pool_stream #(
        .DATA_W(8), .MAP_W(5), .MAP_H(5), .NUM_CH(1), .ADDR_W(8)
    ) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(odat[0]), .out_addr(oadr[0]), .frame_done(fd[0])
    );

    max_pool_stream #(
        .DATA_W(8), .MAP_W(4), .MAP_H(4), .NUM_CH(2), .ADDR_W(8)
    ) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(odat[1]), .out_addr(oadr[1]), .frame_done(fd[1])
    );

    max_pool_stream #(
        .DATA_W(8), .MAP_W(2), .MAP_H(2), .NUM_CH(1), .ADDR_W(8)
    ) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
        .out_valid(ov[2]), .out_ready(orr[2]),
        .out_data(odat[2]), .out_addr(oadr[2]), .frame_done(fd[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes resolve on the next rising edge; inputs change only at posedge+1.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d] && orr[d]) q.push_back('{a: oadr[d], v: odat[d]});
            if (fd[d]) fdc[d]++;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit gt(input logic [7:0] a, input logic [7:0] b);
`ifdef POOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic set_vec(input int i, input logic [7:0] p0,
                           input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p3, input logic [7:0] eu,
                           input logic [7:0] es);
        tbl[i].px[0] = p0;
        tbl[i].px[1] = p1;
        tbl[i].px[2] = p2;
        tbl[i].px[3] = p3;
        tbl[i].eu    = eu;
        tbl[i].es    = es;
    endtask

    task automatic send(input int d, input int base, input int n,
                        input bit stall);
        bit acc;
        int b;
        for (int i = 0; i < n; i++) begin
            acc = 0;
            b   = 0;
            while (!acc && b < 300) begin
                if (stall && $urandom_range(0, 2) == 0) begin
                    iv[d] = 1'b0;
                end else begin
                    iv[d]   = 1'b1;
                    idat[d] = stim[base+i];
                end
                @(negedge clk);
                acc = iv[d] && ir[d];
                @(posedge clk);
                #1;
                b++;
            end
            if (!acc) begin
                check("send_timeout", int'(acc), 1);
                iv[d] = 1'b0;
                return;
            end
        end
        iv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int b;
        b = 0;
        while (ov[d] && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("drain", int'(ov[d]), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string nm, input int base);
        check({nm, "_count"}, q.size() - base, ea.size());
        for (int i = 0; i < ea.size() && base + i < q.size(); i++) begin
            check({nm, "_addr"}, int'(q[base+i].a), int'(ea[i]));
            check({nm, "_data"}, int'(q[base+i].v), int'(ev[i]));
        end
    endtask

    task automatic exp_case1();
        ea.delete();
        ev.delete();
        ev = '{8'd6, 8'd8, 8'd9, 8'd16, 8'd18, 8'd19, 8'd21, 8'd23, 8'd24};
        for (int i = 0; i < 9; i++) ea.push_back(8'(i));
        for (int i = 0; i < 25; i++) stim[i] = 8'(i);
    endtask

    initial begin
        int qb;
        int fb;
        logic [7:0] m;
        logic [7:0] e;

        nchk  = 0;
        nerr  = 0;
        sdone = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            idat[d] = '0;
            orr[d]  = 1'b1;
            fdc[d]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_out_valid", int'(ov[d]), 0);
            check("rst_out_data", int'(odat[d]), 0);
            check("rst_out_addr", int'(oadr[d]), 0);
            check("rst_frame_done", int'(fd[d]), 0);
            check("rst_in_ready", int'(ir[d]), 1);
        end
        @(posedge clk);
        #1;

        // 5x5 ramp
        exp_case1();
        qb = q.size();
        fb = fdc[0];
        send(0, 0, 25, 0);
        drain(0);
        cmp_q("ramp5x5", qb);
        check("ramp5x5_frame_done", fdc[0] - fb, 1);
        if (q.size() > 0) check("ramp5x5_last_addr", int'(q[q.size()-1].a), 8);

        // 4x4, two channels
        for (int i = 0; i < 16; i++) stim[i] = 8'd7;
        for (int i = 0; i < 16; i++) stim[16+i] = 8'(15 - i);
        ea.delete();
        ev.delete();
        ev = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd15, 8'd13, 8'd7, 8'd5};
        for (int i = 0; i < 8; i++) ea.push_back(8'(i));
        qb = q.size();
        fb = fdc[1];
        send(1, 0, 32, 0);
        drain(1);
        cmp_q("ch2_4x4", qb);
        check("ch2_4x4_frame_done", fdc[1] - fb, 1);

        // 2x2 vectors, one frame each; checks one-cycle latency and signedness
        set_vec(0, 8'hFF, 8'h01, 8'h80, 8'h00, 8'hFF, 8'h01);
        set_vec(1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h40);
        set_vec(2, 8'h7F, 8'h80, 8'h00, 8'h01, 8'h80, 8'h7F);
        set_vec(3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        set_vec(4, 8'h81, 8'h82, 8'h83, 8'h84, 8'h84, 8'h84);
        set_vec(5, 8'hFE, 8'hFF, 8'hFD, 8'hFC, 8'hFF, 8'hFF);
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) stim[k] = tbl[t].px[k];
`ifdef POOL_SIGNED_EN
            e = tbl[t].es;
`else
            e = tbl[t].eu;
`endif
            send(2, 0, 4, 0);
            @(negedge clk);
            check("vec_latency_valid", int'(ov[2]), 1);
            check("vec_data", int'(odat[2]), int'(e));
            check("vec_addr", int'(oadr[2]), 0);
            @(negedge clk);
            check("vec_frame_done", int'(fd[2]), 1);
            check("vec_drained", int'(ov[2]), 0);
            @(posedge clk);
            #1;
        end

        // Backpressure: hold the first result for 10 cycles
        exp_case1();
        qb = q.size();
        fb = fdc[0];
        orr[0] = 1'b0;
        fork
            send(0, 0, 25, 0);
            begin
                for (int b = 0; b < 60 && !ov[0]; b++) @(negedge clk);
                check("bp_first_valid", int'(ov[0]), 1);
                for (int k = 0; k < 10; k++) begin
                    check("bp_hold_data", int'(odat[0]), 6);
                    check("bp_hold_addr", int'(oadr[0]), 0);
                    check("bp_in_ready", int'(ir[0]), 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                orr[0] = 1'b1;
            end
        join
        drain(0);
        cmp_q("backpressure", qb);
        check("bp_frame_done", fdc[0] - fb, 1);

        // Reset after 12 of 25 beats, then a clean frame
        send(0, 0, 12, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(ov[0]), 0);
        check("midrst_out_data", int'(odat[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qb = q.size();
        fb = fdc[0];
        send(0, 0, 25, 0);
        drain(0);
        cmp_q("after_reset", qb);
        check("after_reset_frame_done", fdc[0] - fb, 1);

        // Three random frames with stalls on both sides
        for (int i = 0; i < 75; i++) stim[i] = 8'($urandom_range(0, 255));
        ea.delete();
        ev.delete();
        for (int f = 0; f < 3; f++) begin
            for (int pr = 0; pr < 3; pr++) begin
                for (int pc = 0; pc < 3; pc++) begin
                    m = stim[f*25 + 2*pr*5 + 2*pc];
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            if (2*pr+dr < 5 && 2*pc+dc < 5) begin
                                e = stim[f*25 + (2*pr+dr)*5 + 2*pc+dc];
                                if (gt(e, m)) m = e;
                            end
                        end
                    end
                    ea.push_back(8'(pr*3 + pc));
                    ev.push_back(m);
                end
            end
        end
        qb = q.size();
        fb = fdc[0];
        sdone = 0;
        fork
            begin
                send(0, 0, 75, 1);
                sdone = 1;
            end
            begin
                while (!sdone) begin
                    @(posedge clk);
                    #1;
                    orr[0] = 1'($urandom_range(0, 1));
                end
            end
        join
        orr[0] = 1'b1;
        drain(0);
        cmp_q("random3", qb);
        check("random3_frame_done", fdc[0] - fb, 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
